// File: rtl/adc_phs_pkg.sv
// Shared definitions for the ADC clock phase-step controller: FSM encoding,
// command word field positions and default sizing.
package adc_phs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam int CMD_GO_BIT      = 31;
    localparam int CMD_DIR_BIT     = 30;
    localparam int CMD_ACC_CLR_BIT = 29;
    localparam int CMD_RSVD_MSB    = 28;
    localparam int CMD_RSVD_LSB    = 16;
    localparam int CMD_N_MSB       = 15;
    localparam int CMD_N_LSB       = 0;

    localparam int DEF_CNT_W       = 16;
    localparam int DEF_TIMEOUT_CYC = 1023;

endpackage

// File: rtl/adc_phs_step_ctrl_if.sv
// Command, MMCM phase-shift handshake and status bundle of the phase-step controller.
interface adc_phs_step_ctrl_if
    import adc_phs_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic [31:0]      cmd_word;
    logic             ps_en;
    logic             ps_incdec;
    logic             ps_done;
    logic             busy;
    logic [CNT_W-1:0] step_cnt;
    logic [CNT_W-1:0] phase_acc;
    logic             timeout_err;

    modport master (
        output cmd_word,
        output ps_done,
        input  ps_en,
        input  ps_incdec,
        input  busy,
        input  step_cnt,
        input  phase_acc,
        input  timeout_err
    );

    modport slave (
        input  cmd_word,
        input  ps_done,
        output ps_en,
        output ps_incdec,
        output busy,
        output step_cnt,
        output phase_acc,
        output timeout_err
    );
endinterface

// File: rtl/adc_phs_step_ctrl.sv
// Steps the ADC clock MMCM phase N times per software command (toggle-triggered),
// tracking the signed cumulative phase and aborting a step that is never acknowledged.
module adc_phs_step_ctrl
    import adc_phs_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                user_clk,
    input  logic                user_rst_n,
    adc_phs_step_ctrl_if.slave  bus
);
    localparam int             TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    state_t             state_reg, state_next;
    logic [31:0]        cmd_q_reg, cmd_q_next;
    logic               cmd_vld_reg, cmd_vld_next;
    logic               ref_vld_reg, ref_vld_next;
    logic               toggle_ref_reg, toggle_ref_next;
    logic               dir_reg, dir_next;
    logic [CNT_W-1:0]   n_reg, n_next;
    logic [TMO_W-1:0]   tmo_cnt_reg, tmo_cnt_next;
    logic [CNT_W-1:0]   step_cnt_reg, step_cnt_next;
    logic [CNT_W-1:0]   phase_acc_reg, phase_acc_next;
    logic               timeout_err_reg, timeout_err_next;
    logic               ps_en_reg, ps_en_next;
    logic               ps_incdec_reg, ps_incdec_next;
    logic               busy_reg, busy_next;
    logic               accept;
    logic               rsvd_unused;

    assign rsvd_unused = ^cmd_q_reg[CMD_RSVD_MSB:CMD_RSVD_LSB];

    // The toggle reference is only trusted once a real cmd_word sample sits in cmd_q.
    assign accept = (state_reg == ST_IDLE) && ref_vld_reg &&
                    (cmd_q_reg[CMD_GO_BIT] != toggle_ref_reg);

    always_comb begin
        state_next       = state_reg;
        cmd_q_next       = bus.cmd_word;
        cmd_vld_next     = 1'b1;
        ref_vld_next     = ref_vld_reg;
        toggle_ref_next  = toggle_ref_reg;
        dir_next         = dir_reg;
        n_next           = n_reg;
        tmo_cnt_next     = tmo_cnt_reg;
        step_cnt_next    = step_cnt_reg;
        phase_acc_next   = phase_acc_reg;
        timeout_err_next = timeout_err_reg;

        if (cmd_vld_reg && !ref_vld_reg) begin
            ref_vld_next    = 1'b1;
            toggle_ref_next = cmd_q_reg[CMD_GO_BIT];
        end

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    toggle_ref_next  = cmd_q_reg[CMD_GO_BIT];
                    dir_next         = cmd_q_reg[CMD_DIR_BIT];
                    n_next           = CNT_W'(cmd_q_reg[CMD_N_MSB:CMD_N_LSB]);
                    step_cnt_next    = '0;
                    timeout_err_next = 1'b0;
                    if (cmd_q_reg[CMD_ACC_CLR_BIT])
                        phase_acc_next = '0;
                    if (n_next != '0)
                        state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tmo_cnt_next = '0;
                state_next   = ST_WAIT;
            end
            ST_WAIT: begin
                // An acknowledge landing on the last timeout cycle still counts as a step.
                if (bus.ps_done) begin
                    step_cnt_next  = step_cnt_reg + CNT_W'(1);
                    phase_acc_next = phase_acc_reg + (dir_reg ? CNT_W'(1) : {CNT_W{1'b1}});
                    state_next     = (step_cnt_next == n_reg) ? ST_IDLE : ST_ISSUE;
                end else if (tmo_cnt_reg == TMO_LAST) begin
                    timeout_err_next = 1'b1;
                    state_next       = ST_IDLE;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase

        ps_en_next     = (state_next == ST_ISSUE);
        ps_incdec_next = (state_next == ST_ISSUE) && dir_next;
        busy_next      = (state_next != ST_IDLE);
    end

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state_reg       <= ST_IDLE;
            cmd_q_reg       <= '0;
            cmd_vld_reg     <= 1'b0;
            ref_vld_reg     <= 1'b0;
            toggle_ref_reg  <= 1'b0;
            dir_reg         <= 1'b0;
            n_reg           <= '0;
            tmo_cnt_reg     <= '0;
            step_cnt_reg    <= '0;
            phase_acc_reg   <= '0;
            timeout_err_reg <= 1'b0;
            ps_en_reg       <= 1'b0;
            ps_incdec_reg   <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cmd_q_reg       <= cmd_q_next;
            cmd_vld_reg     <= cmd_vld_next;
            ref_vld_reg     <= ref_vld_next;
            toggle_ref_reg  <= toggle_ref_next;
            dir_reg         <= dir_next;
            n_reg           <= n_next;
            tmo_cnt_reg     <= tmo_cnt_next;
            step_cnt_reg    <= step_cnt_next;
            phase_acc_reg   <= phase_acc_next;
            timeout_err_reg <= timeout_err_next;
            ps_en_reg       <= ps_en_next;
            ps_incdec_reg   <= ps_incdec_next;
            busy_reg        <= busy_next;
        end
    end

    assign bus.ps_en       = ps_en_reg;
    assign bus.ps_incdec   = ps_incdec_reg;
    assign bus.busy        = busy_reg;
    assign bus.step_cnt    = step_cnt_reg;
    assign bus.phase_acc   = phase_acc_reg;
    assign bus.timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_adc_phs_step_ctrl.sv
// Directed bench for adc_phs_step_ctrl: a command table with hand-computed results,
// then hand-written sequences for queued toggles, stray acknowledges, reset and wrap.
module tb_adc_phs_step_ctrl;
    import adc_phs_pkg::*;

    localparam int TMO = 16;

    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    adc_phs_step_ctrl_if #(.CNT_W(16)) bus ();
    adc_phs_step_ctrl_if #(.CNT_W(8))  bus8 ();

    adc_phs_step_ctrl #(.TIMEOUT_CYC(TMO), .CNT_W(16)) dut (
        .user_clk   (clk),
        .user_rst_n (rst_n),
        .bus        (bus.slave)
    );

    adc_phs_step_ctrl #(.TIMEOUT_CYC(TMO), .CNT_W(8)) dut8 (
        .user_clk   (clk),
        .user_rst_n (rst_n),
        .bus        (bus8.slave)
    );

    int   checks   = 0;
    int   failures = 0;
    int   resp_dly = 0;
    int   pend     = 0;
    int   en_cnt   = 0;
    int   inc_cnt  = 0;
    logic stray    = 1'b0;
    logic prev8    = 1'b0;

    // MMCM model: acknowledge resp_dly cycles after each ps_en (0 = never).
    initial begin
        bus.ps_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.ps_done = 1'b0;
            if (pend > 0) begin
                pend = pend - 1;
                if (pend == 0) bus.ps_done = 1'b1;
            end
            if (bus.ps_en) begin
                en_cnt = en_cnt + 1;
                if (bus.ps_incdec) inc_cnt = inc_cnt + 1;
                if (resp_dly > 0) pend = resp_dly;
            end
            if (stray) bus.ps_done = 1'b1;
        end
    end

    initial begin
        bus8.ps_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus8.ps_done = prev8;
            prev8 = bus8.ps_en;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    function automatic logic [31:0] mk_cmd(input logic t, input logic d, input logic a,
                                           input logic [15:0] n);
        mk_cmd = {t, d, a, 13'd0, n};
    endfunction

    typedef struct packed {
        logic        dir;
        logic        acc_clr;
        logic [15:0] n;
        int          dly;
        int          exp_en;
        logic [15:0] exp_step;
        logic [15:0] exp_acc;
        logic        exp_err;
    } vec_t;

    vec_t vecs [9];
    logic tog;
    int   lat;
    int   cnt;
    logic seen;

    initial begin
        //            dir  clr  N      dly en  step     acc        err
        vecs[0] = '{1'b1, 1'b1, 16'd3, 4,  3, 16'd3, 16'h0003, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 16'd5, 4,  5, 16'd5, 16'hFFFE, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 16'd2, 1,  2, 16'd2, 16'h0000, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 16'd1, 2,  1, 16'd1, 16'hFFFF, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 16'd2, 0,  1, 16'd0, 16'hFFFF, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 16'd0, 0,  0, 16'd0, 16'hFFFF, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 16'd3, 16, 3, 16'd3, 16'h0002, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 16'd1, 17, 1, 16'd0, 16'h0002, 1'b1};
        vecs[8] = '{1'b0, 1'b1, 16'd4, 3,  4, 16'd4, 16'hFFFC, 1'b0};

        tog = 1'b0;
        bus.cmd_word  = 32'd0;
        bus8.cmd_word = 32'd0;
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_ps_en", {31'd0, bus.ps_en}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_step", {16'd0, bus.step_cnt}, 32'd0);
        check("rst_acc", {16'd0, bus.phase_acc}, 32'd0);
        check("rst_err", {31'd0, bus.timeout_err}, 32'd0);
        rst_n = 1'b1;
        repeat (5) tick();
        check("post_rst_no_en", en_cnt, 0);

        for (int i = 0; i < 9; i++) begin
            en_cnt = 0;
            inc_cnt = 0;
            resp_dly = vecs[i].dly;
            tog = ~tog;
            bus.cmd_word = mk_cmd(tog, vecs[i].dir, vecs[i].acc_clr, vecs[i].n);
            lat = 0;
            seen = 1'b0;
            for (int c = 1; c <= 4 && !seen; c++) begin
                tick();
                if (bus.ps_en) begin
                    seen = 1'b1;
                    lat = c;
                end
            end
            if (vecs[i].n != 16'd0) check($sformatf("v%0d_latency", i), lat, 2);
            else                    check($sformatf("v%0d_no_start", i), {31'd0, seen}, 32'd0);
            cnt = 0;
            while (bus.busy && cnt < 300) begin
                tick();
                cnt++;
            end
            check($sformatf("v%0d_done", i), {31'd0, bus.busy}, 32'd0);
            repeat (4) tick();
            check($sformatf("v%0d_pulses", i), en_cnt, vecs[i].exp_en);
            check($sformatf("v%0d_incdec", i), inc_cnt, vecs[i].dir ? vecs[i].exp_en : 0);
            check($sformatf("v%0d_step", i), {16'd0, bus.step_cnt}, {16'd0, vecs[i].exp_step});
            check($sformatf("v%0d_acc", i), {16'd0, bus.phase_acc}, {16'd0, vecs[i].exp_acc});
            check($sformatf("v%0d_err", i), {31'd0, bus.timeout_err}, {31'd0, vecs[i].exp_err});
        end

        // Toggle flipped mid-command is queued and starts one cycle after IDLE returns.
        en_cnt = 0;
        resp_dly = 2;
        tog = ~tog;
        bus.cmd_word = mk_cmd(tog, 1'b1, 1'b1, 16'd4);
        cnt = 0;
        while (!bus.ps_en && cnt < 4) begin
            tick();
            cnt++;
        end
        check("q_first_start", {31'd0, bus.ps_en}, 32'd1);
        tog = ~tog;
        bus.cmd_word = mk_cmd(tog, 1'b0, 1'b0, 16'd2);
        cnt = 0;
        while (bus.busy && cnt < 300) begin
            tick();
            cnt++;
        end
        check("q_idle_seen", {31'd0, bus.busy}, 32'd0);
        check("q_step_first", {16'd0, bus.step_cnt}, 32'd4);
        check("q_acc_first", {16'd0, bus.phase_acc}, 32'd4);
        tick();
        check("q_restart_en", {31'd0, bus.ps_en}, 32'd1);
        check("q_restart_dir", {31'd0, bus.ps_incdec}, 32'd0);
        cnt = 0;
        while (bus.busy && cnt < 300) begin
            tick();
            cnt++;
        end
        repeat (2) tick();
        check("q_step_second", {16'd0, bus.step_cnt}, 32'd2);
        check("q_acc_second", {16'd0, bus.phase_acc}, 32'd2);
        check("q_pulses", en_cnt, 6);

        // Stray acknowledge in IDLE must not move the counters.
        resp_dly = 0;
        stray = 1'b1;
        tick();
        stray = 1'b0;
        repeat (3) tick();
        check("stray_step", {16'd0, bus.step_cnt}, 32'd2);
        check("stray_acc", {16'd0, bus.phase_acc}, 32'd2);
        check("stray_busy", {31'd0, bus.busy}, 32'd0);

        // Reset in WAIT with the go bit held high through reset.
        tog = ~tog;
        bus.cmd_word = mk_cmd(tog, 1'b1, 1'b0, 16'd3);
        repeat (4) tick();
        check("r_in_wait_busy", {31'd0, bus.busy}, 32'd1);
        bus.cmd_word = mk_cmd(1'b1, 1'b1, 1'b0, 16'd3);
        tog = 1'b1;
        rst_n = 1'b0;
        #1;
        check("r_async_busy", {31'd0, bus.busy}, 32'd0);
        check("r_async_acc", {16'd0, bus.phase_acc}, 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        en_cnt = 0;
        repeat (30) tick();
        check("r_no_en", en_cnt, 0);
        check("r_busy", {31'd0, bus.busy}, 32'd0);
        check("r_step", {16'd0, bus.step_cnt}, 32'd0);
        check("r_err", {31'd0, bus.timeout_err}, 32'd0);

        // Signed wrap on the 8-bit instance: +127 then one more increment.
        bus8.cmd_word = mk_cmd(1'b1, 1'b1, 1'b1, 16'd127);
        repeat (3) tick();
        cnt = 0;
        while (bus8.busy && cnt < 1000) begin
            tick();
            cnt++;
        end
        check("w_done1", {31'd0, bus8.busy}, 32'd0);
        check("w_acc_max", {24'd0, bus8.phase_acc}, 32'h7F);
        check("w_step", {24'd0, bus8.step_cnt}, 32'd127);
        bus8.cmd_word = mk_cmd(1'b0, 1'b1, 1'b0, 16'd1);
        repeat (3) tick();
        cnt = 0;
        while (bus8.busy && cnt < 100) begin
            tick();
            cnt++;
        end
        check("w_acc_wrap", {24'd0, bus8.phase_acc}, 32'h80);
        check("w_err", {31'd0, bus8.timeout_err}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
